manchester_decoder: RTL and testbench
=====================================

MANCHESTER_DECODER -- requirements
Module: manchester_decoder

Interface
REQ-001 SHALL have parameter OSR, default 8: clk cycles per Manchester bit; even, >=8.
REQ-002 SHALL have parameter DATA_W, default 8: payload bits per frame.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx_in  input  1  asynchronous Manchester line, idle low.
REQ-006 SHALL have port out_data  output  DATA_W  decoded payload, LSB received first.
REQ-007 SHALL have port out_valid  output  1  out_data holds an undelivered word.
REQ-008 SHALL have port out_ready  input  1  consumer accepts word when high with out_valid.
REQ-009 SHALL have port err_valid  output  1  one-cycle error pulse.
REQ-010 SHALL have port err_code  output  2  01 missing mid-bit transition, 10 overrun; held until next err_valid.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchronizer (rx_s) plus one delay flop (rx_d); edge = rx_s != rx_d; rising = rx_s high.
REQ-013 SHALL encode bit '1' as rising and '0' as falling mid-bit transition; frame = start bit '1' + DATA_W data bits, LSB first.
REQ-014 SHALL implement FSM IDLE, DATA, GAP.
REQ-015 IDLE: rising edge -> DATA, bit counter=0, cnt=0; falling edges ignored.
REQ-016 cnt SHALL count clk cycles since last accepted mid-bit edge (0 in edge cycle), saturating, width clog2(2*OSR)+1.
REQ-017 In DATA, edge with cnt < 3*OSR/4 SHALL be ignored (bit-boundary transition).
REQ-018 In DATA, edge with 3*OSR/4 <= cnt <= 5*OSR/4 SHALL be accepted: shift in rx_s, cnt=0, bit counter +1.
REQ-019 In DATA, cnt reaching 5*OSR/4+1 without accepted edge SHALL pulse err_valid, err_code=01, discard partial word, go IDLE.
REQ-020 On DATA_W-th accepted data edge SHALL complete word and go GAP.
REQ-021 GAP SHALL last OSR cycles ignoring all edges, then IDLE.
REQ-022 Word completion with out_valid=0, or out_valid=1 and out_ready=1 same cycle, SHALL load out_data, out_valid=1 next cycle.
REQ-023 Word completion with out_valid=1 and out_ready=0 SHALL drop new word, keep old out_data/out_valid, pulse err_valid, err_code=10.
REQ-024 out_valid SHALL clear the cycle after out_ready=1 with no simultaneous completion; out_data stable while out_valid=1.
REQ-025 out_valid SHALL rise on the 3rd clk rising edge after the final data mid-bit transition on rx_in (setup met).
REQ-026 Timeout and overrun cannot coincide; at most one err_valid pulse per frame.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, cnt=0, bit counter=0, synchronizer flops=0, out_data=0, out_valid=0, err_valid=0, err_code=00, busy=0.
REQ-028 Reset mid-frame SHALL discard partial word with no err_valid; after release, first frame needs a fresh rising start edge.
REQ-029 Release of rst_n SHALL be synchronous to clk externally; block needs no further reset sequencing.

Verification (OSR=8, DATA_W=8)
REQ-030 Frame 0xA5, ideal timing, out_ready=1 -> out_valid for 1 cycle, out_data=0xA5, no err_valid, busy low 8 cycles after last bit.
REQ-031 Frames 0x3C then 0xC3, out_ready=0 -> out_data=0x3C held, err_valid once with err_code=10; out_ready=1 then clears out_valid.
REQ-032 Start bit then line held static 11 cycles -> err_valid with err_code=01 at cnt=11, no out_valid, FSM IDLE; next frame 0x0F decodes correctly.
REQ-033 Frame 0xFF with mid-bit edges alternately at cnt=6 and cnt=10 -> out_data=0xFF, no error; edge at cnt=5 ignored, timeout at cnt=11 -> err_code=01.
REQ-034 rst_n pulsed low after 4 data bits -> all outputs reset immediately, no err_valid; subsequent frame 0x81 -> out_data=0x81.
REQ-035 Completion coinciding with out_ready=1 on pending 0x11, new 0x22 -> out_valid stays high, out_data=0x22, no overrun.

Source files
------------

// File: rtl/manchester_decoder.sv
// Manchester line decoder: oversampled mid-bit edge tracking, frame assembly
// (start bit '1' + DATA_W bits, LSB first) and a single-word output register.
module manchester_decoder #(
    parameter int OSR    = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic              busy
);

    // out_valid/out_ready: a word transfers on any rising edge where both are
    // high; out_data is held unchanged for as long as out_valid is high.

    localparam int CNT_W = $clog2(2 * OSR) + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] EARLY_C   = CNT_W'(3 * OSR / 4);
    localparam logic [CNT_W-1:0] LATE_C    = CNT_W'(5 * OSR / 4);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(5 * OSR / 4 + 1);
    localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(OSR);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_OVERRUN = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic              rx_m;
    logic              rx_s;
    logic              rx_d;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;

    logic edge_det;
    logic in_window;
    logic start;
    logic accept;
    logic complete;
    logic timeout;
    logic gap_done;
    logic load_word;
    logic overrun;
    logic [DATA_W-1:0] word;

    // rx_m/rx_s resynchronise the line; rx_d is the previous rx_s for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b0;
            rx_s <= 1'b0;
            rx_d <= 1'b0;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign edge_det  = rx_s ^ rx_d;
    assign in_window = (cnt >= EARLY_C) && (cnt <= LATE_C);
    assign start     = (state == IDLE) && edge_det && rx_s;
    assign accept    = (state == DATA) && edge_det && in_window;
    assign complete  = accept && (bit_cnt == LAST_BIT);
    assign timeout   = (state == DATA) && !accept && (cnt >= TIMEOUT_C);
    assign gap_done  = (state == GAP) && (cnt >= GAP_C);
    assign word      = {rx_s, shift_reg[DATA_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = DATA;
            DATA: begin
                if (complete) begin
                    state_next = GAP;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            GAP:  if (gap_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        load_word = complete && (!out_valid || out_ready);
        overrun   = complete && out_valid && !out_ready;
    end

    // cnt reads k in the cycle an edge arrives k cycles after the last accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (start || accept) begin
                cnt <= CNT_W'(1);
            end else if ((state == IDLE) || timeout || gap_done) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (start || timeout || complete) begin
                bit_cnt <= '0;
            end else if (accept) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (accept) begin
                shift_reg <= word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            if (load_word) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            err_valid <= timeout || overrun;
            if (timeout) begin
                err_code <= ERR_TIMEOUT;
            end else if (overrun) begin
                err_code <= ERR_OVERRUN;
            end
        end
    end

endmodule

// File: tb/tb_manchester_decoder.sv
// Bench for manchester_decoder: table of whole-frame vectors, directed
// multi-cycle sequences, and random frames checked against a word queue.
module tb_manchester_decoder;

    localparam int OSR      = 8;
    localparam int DATA_W   = 8;
    localparam int SYNC_LAT = 3;
    localparam int TO_CNT   = 5 * OSR / 4 + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx_in = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              err_valid;
    logic [1:0]        err_code;
    logic              busy;

    manchester_decoder #(.OSR(OSR), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_valid (err_valid),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: inputs move 1 time unit after posedge, so negedge sees the values
    // that meet at the next rising edge.
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [1:0]        err_q[$];
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    int   err_cyc  = -1;
    int   vhigh    = 0;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;

    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back(out_data);
        if (err_valid) begin
            err_q.push_back(err_code);
            err_cyc = cyc;
        end
        if (out_valid) vhigh++;
        if (out_valid && !prev_valid) rise_cyc = cyc;
        if (!busy && prev_busy) fall_cyc = cyc;
        prev_valid = out_valid;
        prev_busy  = busy;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int last_mid = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start bit rising edge, then nbits data bits; sp_a/sp_b alternate as the
    // spacing between consecutive mid-bit transitions, boundary edge at half.
    task automatic send_frame(input logic [DATA_W-1:0] data, input int sp_a,
                              input int sp_b, input int nbits);
        logic lvl;
        logic b;
        int   s;
        rx_in    = 1'b1;
        lvl      = 1'b1;
        last_mid = cyc;
        for (int i = 0; i < nbits; i++) begin
            b = data[i];
            s = (i % 2 == 0) ? sp_a : sp_b;
            if (b == lvl) begin
                step(s / 2);
                rx_in = ~b;
                step(s - s / 2);
            end else begin
                step(s);
            end
            rx_in    = b;
            lvl      = b;
            last_mid = cyc;
        end
    endtask

    task automatic finish_line();
        step(OSR / 2);
        rx_in = 1'b0;
        step(2 * OSR + 4);
    endtask

    task automatic clear_qs();
        got_q.delete();
        err_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        int         sp_a;
        int         sp_b;
        int         nbits;
        logic       exp_ok;
        logic [7:0] exp_data;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [7:0] d;
        int a;
        int b;

        vecs[0] = '{8'hA5, 8,  8,  8, 1'b1, 8'hA5, 2'b00};
        vecs[1] = '{8'h00, 8,  8,  8, 1'b1, 8'h00, 2'b00};
        vecs[2] = '{8'hFF, 6,  10, 8, 1'b1, 8'hFF, 2'b00};
        vecs[3] = '{8'hFF, 10, 6,  8, 1'b1, 8'hFF, 2'b00};
        vecs[4] = '{8'h55, 6,  6,  8, 1'b1, 8'h55, 2'b00};
        vecs[5] = '{8'hAA, 10, 10, 8, 1'b1, 8'hAA, 2'b00};
        vecs[6] = '{8'h0F, 7,  9,  8, 1'b1, 8'h0F, 2'b00};
        vecs[7] = '{8'h3C, 8,  8,  3, 1'b0, 8'h00, 2'b01};
        vecs[8] = '{8'hC3, 8,  8,  0, 1'b0, 8'h00, 2'b01};
        vecs[9] = '{8'h96, 6,  6,  7, 1'b0, 8'h00, 2'b01};

        // Reset state, during and after reset.
        step(3);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_err_valid", int'(err_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        step(4);
        check("post_rst_out_data", int'(out_data), 0);
        check("post_rst_err_code", int'(err_code), 0);
        check("post_rst_busy", int'(busy), 0);

        // 0xA5, ideal timing: latency, single-cycle valid, GAP length.
        out_ready = 1'b1;
        clear_qs();
        vhigh = 0;
        send_frame(8'hA5, 8, 8, 8);
        c = last_mid;
        finish_line();
        check("a5_words", got_q.size(), 1);
        if (got_q.size() > 0) check("a5_data", int'(got_q[0]), 'hA5);
        check("a5_valid_latency", rise_cyc - c, SYNC_LAT);
        check("a5_valid_cycles", vhigh, 1);
        check("a5_errs", err_q.size(), 0);
        check("a5_busy_fall", fall_cyc - c, SYNC_LAT + OSR);

        // Table-driven frames.
        foreach (vecs[i]) begin
            clear_qs();
            out_ready = 1'b1;
            send_frame(vecs[i].data, vecs[i].sp_a, vecs[i].sp_b, vecs[i].nbits);
            if (vecs[i].nbits == DATA_W) begin
                finish_line();
            end else begin
                step(2 * OSR);
                rx_in = 1'b0;
                step(2 * OSR);
            end
            check($sformatf("vec%0d_words", i), got_q.size(), vecs[i].exp_ok ? 1 : 0);
            if (vecs[i].exp_ok && got_q.size() > 0)
                check($sformatf("vec%0d_data", i), int'(got_q[0]), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_errs", i), err_q.size(), vecs[i].exp_ok ? 0 : 1);
            if (!vecs[i].exp_ok && err_q.size() > 0)
                check($sformatf("vec%0d_code", i), int'(err_q[0]), int'(vecs[i].exp_code));
            check($sformatf("vec%0d_busy", i), int'(busy), 0);
        end

        // Overrun: 0x3C pending, 0xC3 dropped.
        out_ready = 1'b0;
        clear_qs();
        send_frame(8'h3C, 8, 8, 8);
        finish_line();
        send_frame(8'hC3, 8, 8, 8);
        finish_line();
        check("ovr_valid", int'(out_valid), 1);
        check("ovr_data", int'(out_data), 'h3C);
        check("ovr_errs", err_q.size(), 1);
        if (err_q.size() > 0) check("ovr_code", int'(err_q[0]), 2);
        check("ovr_code_held", int'(err_code), 2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("ovr_drain_valid", int'(out_valid), 0);
        check("ovr_drain_words", got_q.size(), 1);
        if (got_q.size() > 0) check("ovr_drain_data", int'(got_q[0]), 'h3C);
        step(2);

        // Start bit then static line: timeout, then a clean 0x0F.
        out_ready = 1'b1;
        clear_qs();
        rx_in = 1'b1;
        c = cyc;
        step(2 * OSR);
        check("to_errs", err_q.size(), 1);
        if (err_q.size() > 0) check("to_code", int'(err_q[0]), 1);
        check("to_err_time", err_cyc - c, SYNC_LAT + TO_CNT);
        check("to_words", got_q.size(), 0);
        check("to_busy", int'(busy), 0);
        rx_in = 1'b0;
        step(2 * OSR);
        send_frame(8'h0F, 8, 8, 8);
        finish_line();
        check("after_to_words", got_q.size(), 1);
        if (got_q.size() > 0) check("after_to_data", int'(got_q[0]), 'h0F);
        check("after_to_errs", err_q.size(), 1);

        // Edge at cnt=5 is ignored; timeout still fires at cnt=11.
        clear_qs();
        rx_in = 1'b1;
        c = cyc;
        step(5);
        rx_in = 1'b0;
        step(2 * OSR);
        check("early_errs", err_q.size(), 1);
        if (err_q.size() > 0) check("early_code", int'(err_q[0]), 1);
        check("early_err_time", err_cyc - c, SYNC_LAT + TO_CNT);
        check("early_words", got_q.size(), 0);
        step(2 * OSR);

        // Completion coinciding with out_ready on a pending word.
        out_ready = 1'b0;
        clear_qs();
        send_frame(8'h11, 8, 8, 8);
        finish_line();
        check("pend_valid", int'(out_valid), 1);
        send_frame(8'h22, 8, 8, 8);
        step(SYNC_LAT - 1);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(1);
        rx_in = 1'b0;
        step(2 * OSR + 4);
        check("swap_valid", int'(out_valid), 1);
        check("swap_data", int'(out_data), 'h22);
        check("swap_errs", err_q.size(), 0);
        check("swap_words", got_q.size(), 1);
        if (got_q.size() > 0) check("swap_first", int'(got_q[0]), 'h11);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        check("swap_drain_words", got_q.size(), 2);
        if (got_q.size() > 1) check("swap_second", int'(got_q[1]), 'h22);
        step(2);

        // Reset after 4 data bits.
        out_ready = 1'b1;
        clear_qs();
        send_frame(8'h5A, 8, 8, 4);
        step(2);
        check("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_data", int'(out_data), 0);
        check("mid_rst_err_valid", int'(err_valid), 0);
        check("mid_rst_err_code", int'(err_code), 0);
        check("mid_rst_busy", int'(busy), 0);
        step(3);
        rx_in = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(4);
        send_frame(8'h81, 8, 8, 8);
        finish_line();
        check("mid_rst_errs", err_q.size(), 0);
        check("mid_rst_words", got_q.size(), 1);
        if (got_q.size() > 0) check("mid_rst_next", int'(got_q[0]), 'h81);

        // Random frames with random in-window spacing.
        out_ready = 1'b1;
        clear_qs();
        exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            d = 8'($urandom_range(0, 255));
            a = $urandom_range(3 * OSR / 4, 5 * OSR / 4);
            b = $urandom_range(3 * OSR / 4, 5 * OSR / 4);
            exp_q.push_back(d);
            send_frame(d, a, b, 8);
            finish_line();
        end
        check("rand_words", got_q.size(), exp_q.size());
        check("rand_errs", err_q.size(), 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size())
                check($sformatf("rand_data%0d", k), int'(got_q[k]), int'(exp_q[k]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
